// File: rtl/avg_unpooling.sv
// avg_unpooling: 2x2 nearest-neighbour unpooling of a raster pixel stream.
// Each pooled pixel is written into the output twice on an even output row and
// stored in a one-row line buffer. The odd row that follows replays the line buffer.
// Ports:
//   clk, rst_n (async active-low)
//   in_valid/in_ready/in_data      pooled pixel input, raster order
//   out_valid/out_ready/out_data   upsampled pixel output, raster order
//   out_sof, out_eol               first pixel of frame, last pixel of row
//   frame_done                     pulse the cycle after the last pixel of a frame is taken
// Optional: define AVG_UNPOOL_ZERO_FILL_EN for sparse unpooling. In that mode only the
//   top-left pixel of each 2x2 block carries data and the other three are 0.
module avg_unpooling #(
  parameter int DATA_W   = 8,
  parameter int OUT_COLS = 28,
  parameter int OUT_ROWS = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  output logic              frame_done
);
  localparam int HALF = OUT_COLS / 2;
  localparam int CW   = $clog2(OUT_COLS);
  localparam int RW   = $clog2(OUT_ROWS);
  localparam int HW   = HALF > 1 ? $clog2(HALF) : 1;
  typedef enum logic {FILL, REPLAY} state_e;
  state_e            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_sof_q, out_sof_d;
  logic              out_eol_q, out_eol_d;
  logic              out_last_q, out_last_d;
  logic              frame_done_q, frame_done_d;
  logic [DATA_W-1:0] lb_q [HALF];
  logic [HW-1:0]     lb_idx;
  logic              fire, can_load, need_in, load, col_last, row_last;
  logic [DATA_W-1:0] load_data;
  // col_q/row_q give the position of the next pixel to be loaded into the output register.
  assign lb_idx   = HW'(col_q >> 1);
  assign fire     = out_valid_q && out_ready;
  assign can_load = !out_valid_q || fire;
  assign need_in  = state_q == FILL && !col_q[0];
  assign in_ready = can_load && need_in;
  assign load     = can_load && (!need_in || in_valid);
  assign col_last = col_q == CW'(OUT_COLS - 1);
  assign row_last = row_q == RW'(OUT_ROWS - 1);
`ifdef AVG_UNPOOL_ZERO_FILL_EN
  assign load_data = need_in ? in_data : '0;
`else
  // The duplicate pixel on a fill row is still held in the output register.
  assign load_data = need_in ? in_data : (state_q == FILL ? out_data_q : lb_q[lb_idx]);
`endif
  always_comb begin
    out_valid_d  = can_load ? load : out_valid_q;
    out_data_d   = load ? load_data : out_data_q;
    out_sof_d    = load ? (col_q == '0 && row_q == '0) : out_sof_q;
    out_eol_d    = load ? col_last : out_eol_q;
    out_last_d   = load ? (col_last && row_last) : out_last_q;
    frame_done_d = fire && out_last_q;
    col_d        = load ? (col_last ? '0 : col_q + 1'b1) : col_q;
    row_d        = (load && col_last) ? (row_last ? '0 : row_q + 1'b1) : row_q;
    state_d      = (load && col_last) ? (state_q == FILL ? REPLAY : FILL) : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sof_q    <= 1'b0;
      out_eol_q    <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sof_q    <= out_sof_d;
      out_eol_q    <= out_eol_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) lb_q[lb_idx] <= in_data;
  end
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_sof    = out_sof_q;
  assign out_eol    = out_eol_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_avg_unpooling.sv
// tb_avg_unpooling: directed checks of avg_unpooling at 4x4 output, 8-bit pixels.
module tb_avg_unpooling;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, out_valid, out_ready, out_sof, out_eol, frame_done;
  logic [7:0] in_data, out_data;
  int n_tests = 0, n_fail = 0, pos = 0, n_out = 0, n_fd = 0, n_bub = 0;
  bit fd_pend = 0, hold_v = 0, rdy_rand = 0, bub_en = 0, abort = 0, drv_busy = 0;
  logic [9:0] hold_val;
  logic [7:0] exp_q[$];
  logic [7:0] px_q[$];
  int map [16] = '{0, 0, 1, 1, 0, 0, 1, 1, 2, 2, 3, 3, 2, 2, 3, 3};
`ifdef AVG_UNPOOL_ZERO_FILL_EN
  int keep [16] = '{1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
`else
  int keep [16] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif

  avg_unpooling #(.DATA_W(8), .OUT_COLS(4), .OUT_ROWS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    logic [7:0] p [4];
    p = '{a, b, c, d};
    for (int i = 0; i < 16; i++) exp_q.push_back(keep[i] != 0 ? p[map[i]] : 8'd0);
    for (int i = 0; i < 4; i++) px_q.push_back(p[i]);
  endtask

  task automatic drive();
    int t;
    drv_busy = 1;
    while (px_q.size() > 0 && !abort) begin
      t = 0;
      in_valid = 1'b1;
      in_data = px_q[0];
      do begin
        @(negedge clk);
        t++;
      end while (!in_ready && t < 200 && !abort);
      if (abort) break;
      if (!in_ready) begin
        check("in_accept_timeout", 32'(in_ready), 32'd1);
        px_q.delete();
        break;
      end
      @(posedge clk);
      #1;
      void'(px_q.pop_front());
    end
    in_valid = 1'b0;
    drv_busy = 0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'd0);
    check({tag, "_sof"}, 32'(out_sof), 32'd0);
    check({tag, "_eol"}, 32'(out_eol), 32'd0);
    check({tag, "_fdone"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (fd_pend || frame_done) check("frame_done", 32'(frame_done), 32'(fd_pend));
        if (frame_done) n_fd++;
        fd_pend = 0;
        if (hold_v) check("stall_hold", 32'({out_data, out_sof, out_eol}), 32'(hold_val));
        hold_v = 0;
        if (bub_en && out_ready && !out_valid && exp_q.size() > 0) n_bub++;
        if (out_valid && in_valid && ((pos / 4) % 2 == 1 ? pos % 4 != 3 : pos % 2 == 0))
          check("in_ready_blocked", 32'(in_ready), 32'd0);
        else if (out_valid && in_valid && out_ready && (pos / 4) % 2 == 0 && pos % 4 == 1)
          check("in_ready_dup", 32'(in_ready), 32'd1);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) check("extra_output", 32'(out_data), 32'hFFFF);
          else begin
            e = exp_q.pop_front();
            check("data", 32'(out_data), 32'(e));
            check("sof", 32'(out_sof), 32'(pos == 0));
            check("eol", 32'(out_eol), 32'(pos % 4 == 3));
            pos = (pos + 1) % 16;
            fd_pend = pos == 0;
            n_out++;
          end
        end else if (out_valid) begin
          hold_v = 1;
          hold_val = {out_data, out_sof, out_eol};
        end
      end
    end
  end

  initial begin
    int t;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    push_frame(8'd10, 8'd20, 8'd30, 8'd40);
    drive();
    wait_drain();
    rdy_rand = 1;
    push_frame(8'd10, 8'd20, 8'd30, 8'd40);
    drive();
    wait_drain();
    rdy_rand = 0;
    n_out = 0;
    push_frame(8'd50, 8'd60, 8'd70, 8'd80);
    fork
      drive();
    join_none
    t = 0;
    while (n_out < 5 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("reach_5_outputs", 32'(n_out >= 5), 32'd1);
    @(posedge clk);
    #1;
    abort = 1;
    rst_n = 1'b0;
    exp_q.delete();
    px_q.delete();
    pos = 0;
    fd_pend = 0;
    hold_v = 0;
    #1;
    check_idle("midreset");
    t = 0;
    while (drv_busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("driver_abort", 32'(drv_busy), 32'd0);
    @(negedge clk);
    check_idle("midreset_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    abort = 0;
    push_frame(8'd1, 8'd2, 8'd3, 8'd4);
    drive();
    wait_drain();
    n_fd = 0;
    n_bub = 0;
    n_out = 0;
    bub_en = 1;
    push_frame(8'd11, 8'd22, 8'd33, 8'd44);
    push_frame(8'd55, 8'd66, 8'd77, 8'd88);
    drive();
    wait_drain();
    bub_en = 0;
    check("b2b_outputs", 32'(n_out), 32'd32);
    check("b2b_frame_done_count", 32'(n_fd), 32'd2);
    check("b2b_bubbles_ok", 32'(n_bub <= 8), 32'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
